// File: rtl/morse_receiver_if.sv
// Character/element output bus of the Morse receiver.
// Signals:
//   CharValid  one-cycle strobe, CharCode/CharError valid
//   CharCode   6-bit character code (0-25 A-Z, 26-35 digits, 36 space, 63 error)
//   CharError  high with CharValid when the character could not be decoded
//   ElemValid  one-cycle strobe per classified element
//   isDash     element class qualified by ElemValid (1 = dash)
//   Busy       high while a character is being assembled
// Modports: master (receiver drives), slave (consumer samples).
interface morse_receiver_if;
  logic       CharValid;
  logic [5:0] CharCode;
  logic       CharError;
  logic       ElemValid;
  logic       isDash;
  logic       Busy;

  modport master (
    output CharValid, CharCode, CharError, ElemValid, isDash, Busy
  );

  modport slave (
    input CharValid, CharCode, CharError, ElemValid, isDash, Busy
  );
endinterface

// File: rtl/morse_receiver.sv
// Morse receiver: samples the demodulated light line once per Morse unit,
// measures mark/space run lengths, classifies marks as dot/dash, assembles
// up to 6 elements and decodes them to a character code on the inter-character
// gap.
// Optional feature macro: MORSE_RX_SPACE_EN -- when defined a word gap emits
// one space code (36); when undefined the word gap silently returns to idle.
// Ports:
//   UnitClock  one rising edge per Morse unit (sole clock)
//   ResetN     asynchronous active-low reset
//   ONOFF      raw detector line, asynchronous to UnitClock (1 = light on)
//   rx         output bus (morse_receiver_if.master), all outputs registered
module morse_receiver #(
  parameter int unsigned DASH_MIN     = 2,
  parameter int unsigned CHAR_GAP_MIN = 3,
  parameter int unsigned WORD_GAP_MIN = 7,
  parameter int unsigned RUN_W        = 4
) (
  input  logic             UnitClock,
  input  logic             ResetN,
  input  logic             ONOFF,
  morse_receiver_if.master rx
);

  localparam int unsigned ELEM_MAX = 6;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned CODE_W   = 6;

  localparam logic [CODE_W-1:0] CODE_ERR   = CODE_W'(63);
  localparam logic [CODE_W-1:0] CODE_SPACE = CODE_W'(36);
  localparam logic [RUN_W-1:0]  RUN_MAX    = '1;
  localparam logic [RUN_W-1:0]  RUN_ONE    = RUN_W'(1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

  state_t                state, state_n;
  logic                  sync1, s, prev;
  logic [RUN_W-1:0]      run, run_n;
  logic [ELEM_MAX-1:0]   elem_buf, elem_buf_n;
  logic [CNT_W-1:0]      elem_cnt, elem_cnt_n;
  logic                  ovf, ovf_n;
  logic                  char_valid, char_valid_n;
  logic [CODE_W-1:0]     char_code, char_code_n;
  logic                  char_error, char_error_n;
  logic                  elem_valid, elem_valid_n;
  logic                  is_dash, is_dash_n;
  logic                  busy, busy_n;

  logic [RUN_W-1:0]      run_inc_c;
  logic                  mark_dash_c;

  // ITU table; elements arrive MSB-first, 1 = dash, upper unused bits zero.
  function automatic logic [CODE_W-1:0] lookup(input logic [CNT_W-1:0] n,
                                               input logic [ELEM_MAX-1:0] b);
    logic [CODE_W-1:0] code;
    case ({n, b})
      9'b010_000001: code = CODE_W'(0);   // A .-
      9'b100_001000: code = CODE_W'(1);   // B -...
      9'b100_001010: code = CODE_W'(2);   // C -.-.
      9'b011_000100: code = CODE_W'(3);   // D -..
      9'b001_000000: code = CODE_W'(4);   // E .
      9'b100_000010: code = CODE_W'(5);   // F ..-.
      9'b011_000110: code = CODE_W'(6);   // G --.
      9'b100_000000: code = CODE_W'(7);   // H ....
      9'b010_000000: code = CODE_W'(8);   // I ..
      9'b100_000111: code = CODE_W'(9);   // J .---
      9'b011_000101: code = CODE_W'(10);  // K -.-
      9'b100_000100: code = CODE_W'(11);  // L .-..
      9'b010_000011: code = CODE_W'(12);  // M --
      9'b010_000010: code = CODE_W'(13);  // N -.
      9'b011_000111: code = CODE_W'(14);  // O ---
      9'b100_000110: code = CODE_W'(15);  // P .--.
      9'b100_001101: code = CODE_W'(16);  // Q --.-
      9'b011_000010: code = CODE_W'(17);  // R .-.
      9'b011_000000: code = CODE_W'(18);  // S ...
      9'b001_000001: code = CODE_W'(19);  // T -
      9'b011_000001: code = CODE_W'(20);  // U ..-
      9'b100_000001: code = CODE_W'(21);  // V ...-
      9'b011_000011: code = CODE_W'(22);  // W .--
      9'b100_001001: code = CODE_W'(23);  // X -..-
      9'b100_001011: code = CODE_W'(24);  // Y -.--
      9'b100_001100: code = CODE_W'(25);  // Z --..
      9'b101_011111: code = CODE_W'(26);  // 0 -----
      9'b101_001111: code = CODE_W'(27);  // 1 .----
      9'b101_000111: code = CODE_W'(28);  // 2 ..---
      9'b101_000011: code = CODE_W'(29);  // 3 ...--
      9'b101_000001: code = CODE_W'(30);  // 4 ....-
      9'b101_000000: code = CODE_W'(31);  // 5 .....
      9'b101_010000: code = CODE_W'(32);  // 6 -....
      9'b101_011000: code = CODE_W'(33);  // 7 --...
      9'b101_011100: code = CODE_W'(34);  // 8 ---..
      9'b101_011110: code = CODE_W'(35);  // 9 ----.
      default:       code = CODE_ERR;
    endcase
    return code;
  endfunction

  // Saturating run increment and mark classification.
  assign run_inc_c   = (run == RUN_MAX) ? run : run + RUN_ONE;
  assign mark_dash_c = (run >= RUN_W'(DASH_MIN));

  // Synchronizer and prev reset high so a line held on through reset is
  // ignored until it has been seen low.
  always_ff @(posedge UnitClock or negedge ResetN) begin
    if (!ResetN) begin
      sync1      <= 1'b1;
      s          <= 1'b1;
      prev       <= 1'b1;
      state      <= IDLE;
      run        <= '0;
      elem_buf   <= '0;
      elem_cnt   <= '0;
      ovf        <= 1'b0;
      char_valid <= 1'b0;
      char_code  <= '0;
      char_error <= 1'b0;
      elem_valid <= 1'b0;
      is_dash    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync1      <= ONOFF;
      s          <= sync1;
      prev       <= s;
      state      <= state_n;
      run        <= run_n;
      elem_buf   <= elem_buf_n;
      elem_cnt   <= elem_cnt_n;
      ovf        <= ovf_n;
      char_valid <= char_valid_n;
      char_code  <= char_code_n;
      char_error <= char_error_n;
      elem_valid <= elem_valid_n;
      is_dash    <= is_dash_n;
      busy       <= busy_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    run_n        = run;
    elem_buf_n   = elem_buf;
    elem_cnt_n   = elem_cnt;
    ovf_n        = ovf;
    char_valid_n = 1'b0;
    char_code_n  = char_code;
    char_error_n = 1'b0;
    elem_valid_n = 1'b0;
    is_dash_n    = 1'b0;
    busy_n       = busy;

    case (state)
      IDLE: begin
        if (s && !prev) begin
          state_n = MARK;
          run_n   = RUN_ONE;
          busy_n  = 1'b1;
        end
      end

      MARK: begin
        if (s) begin
          run_n = run_inc_c;
        end else begin
          elem_valid_n = 1'b1;
          is_dash_n    = mark_dash_c;
          if (elem_cnt < CNT_W'(ELEM_MAX)) begin
            elem_buf_n = {elem_buf[ELEM_MAX-2:0], mark_dash_c};
            elem_cnt_n = elem_cnt + CNT_W'(1);
          end else begin
            ovf_n = 1'b1;
          end
          state_n = SPACE;
          run_n   = RUN_ONE;
        end
      end

      SPACE: begin
        if (s) begin
          state_n = MARK;
          run_n   = RUN_ONE;
        end else begin
          run_n = run_inc_c;
          if (run_inc_c >= RUN_W'(CHAR_GAP_MIN)) begin
            char_valid_n = 1'b1;
            char_code_n  = ovf ? CODE_ERR : lookup(elem_cnt, elem_buf);
            char_error_n = (char_code_n == CODE_ERR);
            elem_buf_n   = '0;
            elem_cnt_n   = '0;
            ovf_n        = 1'b0;
            busy_n       = 1'b0;
            state_n      = GAP;
          end
        end
      end

      GAP: begin
        if (s) begin
          state_n = MARK;
          run_n   = RUN_ONE;
          busy_n  = 1'b1;
        end else begin
          run_n = run_inc_c;
          if (run_inc_c >= RUN_W'(WORD_GAP_MIN)) begin
`ifdef MORSE_RX_SPACE_EN
            char_valid_n = 1'b1;
            char_code_n  = CODE_SPACE;
            char_error_n = 1'b0;
`endif
            state_n = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign rx.CharValid = char_valid;
  assign rx.CharCode  = char_code;
  assign rx.CharError = char_error;
  assign rx.ElemValid = elem_valid;
  assign rx.isDash    = is_dash;
  assign rx.Busy      = busy;

endmodule

// File: tb/tb_morse_receiver.sv
// Self-checking bench for morse_receiver: table-driven character vectors plus
// hand-written sequences for latency/word gap and reset mid-character.
module tb_morse_receiver;

  logic clk = 1'b0;
  logic rst_n;
  logic onoff;

  morse_receiver_if bus ();

  morse_receiver dut (
    .UnitClock (clk),
    .ResetN    (rst_n),
    .ONOFF     (onoff),
    .rx        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic       dash_q[$];
  logic [6:0] char_q[$];   // {err, code}

  // Event recorder, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ElemValid) dash_q.push_back(bus.isDash);
      if (bus.CharValid) char_q.push_back({bus.CharError, bus.CharCode});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Characters other than the optional word-gap space.
  function automatic int real_chars();
    int n = 0;
    foreach (char_q[i]) if (char_q[i][5:0] != 6'd36) n++;
    return n;
  endfunction

  task automatic real_char(input int idx, output logic [6:0] v);
    int n = 0;
    v = 7'h7f;
    foreach (char_q[i]) begin
      if (char_q[i][5:0] != 6'd36) begin
        if (n == idx) v = char_q[i];
        n++;
      end
    end
  endtask

  task automatic apply(input logic [63:0] seq, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      @(negedge clk);
      onoff = seq[i];
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      onoff = 1'b0;
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] seq;
    int          len;
    int          n_elem;
    logic [7:0]  dash;    // bit i = i-th received element
    logic [5:0]  code;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [6:0] ch;
    int         n_space;

    vecs[0] = '{"S",      64'b10101,               5, 3, 8'b000,     6'd18, 1'b0};
    vecs[1] = '{"O",      64'b11101110111,        11, 3, 8'b111,     6'd14, 1'b0};
    vecs[2] = '{"zero",   64'b1110111011101110111, 19, 5, 8'b11111,  6'd26, 1'b0};
    vecs[3] = '{"7dots",  64'b1010101010101,      13, 7, 8'b0000000, 6'd63, 1'b1};
    vecs[4] = '{"4dash",  64'b111011101110111,    15, 4, 8'b1111,    6'd63, 1'b1};
    vecs[5] = '{"A",      64'b10111,               5, 2, 8'b10,      6'd0,  1'b0};
    vecs[6] = '{"E",      64'b1,                   1, 1, 8'b0,       6'd4,  1'b0};
    vecs[7] = '{"T",      64'b111,                 3, 1, 8'b1,       6'd19, 1'b0};
    vecs[8] = '{"nine",   64'b11101110111011101,  17, 5, 8'b01111,   6'd35, 1'b0};
    vecs[9] = '{"glitchM",64'b11011,               5, 2, 8'b11,      6'd12, 1'b0};

    // Reset state
    rst_n = 1'b0;
    onoff = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_CharValid", bus.CharValid, 0);
    check("rst_CharCode",  bus.CharCode,  0);
    check("rst_CharError", bus.CharError, 0);
    check("rst_ElemValid", bus.ElemValid, 0);
    check("rst_isDash",    bus.isDash,    0);
    check("rst_Busy",      bus.Busy,      0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven characters
    for (int v = 0; v < 10; v++) begin
      dash_q.delete();
      char_q.delete();
      apply(vecs[v].seq, vecs[v].len);
      check({vecs[v].name, "_elems"}, dash_q.size(), vecs[v].n_elem);
      for (int e = 0; e < vecs[v].n_elem && e < dash_q.size(); e++)
        check($sformatf("%s_dash%0d", vecs[v].name, e), dash_q[e], vecs[v].dash[e]);
      check({vecs[v].name, "_nchar"}, real_chars(), 1);
      real_char(0, ch);
      check({vecs[v].name, "_code"}, ch[5:0], vecs[v].code);
      check({vecs[v].name, "_err"},  ch[6],   vecs[v].err);
      check({vecs[v].name, "_busy"}, bus.Busy, 0);
    end

    // SOS stream: codes in order
    dash_q.delete();
    char_q.delete();
    apply(64'b101010001110111011100010101, 27);
    check("sos_elems", dash_q.size(), 9);
    check("sos_nchar", real_chars(), 3);
    real_char(0, ch); check("sos_c0", ch, {1'b0, 6'd18});
    real_char(1, ch); check("sos_c1", ch, {1'b0, 6'd14});
    real_char(2, ch); check("sos_c2", ch, {1'b0, 6'd18});

    // Latency and word gap: 1 followed by zeros
    dash_q.delete();
    char_q.delete();
    @(negedge clk);
    onoff = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic exp_cv;
      @(negedge clk);
`ifdef MORSE_RX_SPACE_EN
      exp_cv = (i == 5) || (i == 9);
`else
      exp_cv = (i == 5);
`endif
      check($sformatf("lat_ev%0d", i), bus.ElemValid, (i == 3));
      check($sformatf("lat_cv%0d", i), bus.CharValid, exp_cv);
      if (i == 2) check("lat_busy_mid", bus.Busy, 1);
      if (i == 5) check("lat_code_E", bus.CharCode, 4);
`ifdef MORSE_RX_SPACE_EN
      if (i == 9) begin
        check("lat_code_space", bus.CharCode, 36);
        check("lat_err_space",  bus.CharError, 0);
      end
`endif
      onoff = 1'b0;
    end
    repeat (4) @(negedge clk);
    n_space = 0;
    foreach (char_q[i]) if (char_q[i][5:0] == 6'd36) n_space++;
`ifdef MORSE_RX_SPACE_EN
    check("word_space_count", n_space, 1);
`else
    check("word_space_count", n_space, 0);
`endif
    check("word_total_chars", char_q.size(), 1 + n_space);

    // Reset during the second dash of O
    dash_q.delete();
    char_q.delete();
    @(negedge clk); onoff = 1'b1;
    @(negedge clk); onoff = 1'b1;
    @(negedge clk); onoff = 1'b1;
    @(negedge clk); onoff = 1'b0;
    @(negedge clk); onoff = 1'b1;
    @(negedge clk); onoff = 1'b1;
    @(negedge clk);
    check("pre_rst_busy", bus.Busy, 1);
    check("pre_rst_ev",   bus.ElemValid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_CharValid", bus.CharValid, 0);
    check("mid_rst_CharCode",  bus.CharCode,  0);
    check("mid_rst_CharError", bus.CharError, 0);
    check("mid_rst_ElemValid", bus.ElemValid, 0);
    check("mid_rst_isDash",    bus.isDash,    0);
    check("mid_rst_Busy",      bus.Busy,      0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dash_q.delete();
    char_q.delete();
    repeat (8) @(negedge clk);
    check("held_high_elems", dash_q.size(), 0);
    check("held_high_busy",  bus.Busy, 0);
    apply(64'b010101, 6);
    check("post_rst_elems", dash_q.size(), 3);
    check("post_rst_nchar", real_chars(), 1);
    real_char(0, ch);
    check("post_rst_code", ch, {1'b0, 6'd18});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
